// File: rtl/snake_body_tracker_if.sv
// Control, query and status bundle between the game
// logic and the snake body tracker.
interface snake_body_tracker_if #(
    parameter int XW = 4,
    parameter int YW = 4
);
    logic [3:0]    dir;
    logic          tick;
    logic          start;
    logic          grow;
    logic [XW-1:0] qx;
    logic [YW-1:0] qy;
    logic          occupied;
    logic [XW-1:0] head_x;
    logic [YW-1:0] head_y;
    logic [5:0]    len;
    logic          moved;
    logic          game_over;
    logic          running;

    modport master (
        output dir, tick, start, grow, qx, qy,
        input  occupied, head_x, head_y, len,
        input  moved, game_over, running
    );

    modport slave (
        input  dir, tick, start, grow, qx, qy,
        output occupied, head_x, head_y, len,
        output moved, game_over, running
    );
endinterface

// File: rtl/snake_body_tracker.sv
// Snake body history, movement, growth and collision detection.
// Optional macro SNAKE_WRAP_EN: board edges wrap instead of killing.
module snake_body_tracker #(
    parameter int GRID_W    = 16,
    parameter int GRID_H    = 16,
    parameter int XW        = 4,
    parameter int YW        = 4,
    parameter int MAX_LEN   = 8,
    parameter int START_X   = 4,
    parameter int START_Y   = 8,
    parameter int START_LEN = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    snake_body_tracker_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_OVER
    } state_t;

    localparam logic [1:0] D_LEFT  = 2'b00;
    localparam logic [1:0] D_RIGHT = 2'b01;
    localparam logic [1:0] D_UP    = 2'b10;
    localparam logic [1:0] D_DOWN  = 2'b11;

    localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [XW-1:0] r_seg_x [MAX_LEN];
    logic [YW-1:0] r_seg_y [MAX_LEN];
    logic [5:0]    r_len;
    logic          r_grow_pending;
    logic          r_moved;

    logic [XW-1:0] w_nx;
    logic [YW-1:0] w_ny;
    logic          w_edge;
    logic          w_wall;
    logic          w_self;
    logic          w_len_inc;
    logic          w_move;
    logic          w_reinit;
    logic          w_occ;
    logic          w_unused_dir;

    assign w_unused_dir = ^bus.dir[3:2];

    // A step only lengthens the body if growth is owed and there is room.
    assign w_len_inc = (r_grow_pending | bus.grow)
                     & (r_len < 6'(MAX_LEN));

    // Candidate head cell, with edge detection and wrapped coordinate.
    always_comb begin
        w_nx   = r_seg_x[0];
        w_ny   = r_seg_y[0];
        w_edge = 1'b0;
        unique case (bus.dir[1:0])
            D_LEFT: begin
                if (r_seg_x[0] == '0) begin
                    w_edge = 1'b1;
                    w_nx   = X_MAX;
                end else begin
                    w_nx = r_seg_x[0] - 1'b1;
                end
            end
            D_RIGHT: begin
                if (r_seg_x[0] == X_MAX) begin
                    w_edge = 1'b1;
                    w_nx   = '0;
                end else begin
                    w_nx = r_seg_x[0] + 1'b1;
                end
            end
            D_UP: begin
                if (r_seg_y[0] == '0) begin
                    w_edge = 1'b1;
                    w_ny   = Y_MAX;
                end else begin
                    w_ny = r_seg_y[0] - 1'b1;
                end
            end
            D_DOWN: begin
                if (r_seg_y[0] == Y_MAX) begin
                    w_edge = 1'b1;
                    w_ny   = '0;
                end else begin
                    w_ny = r_seg_y[0] + 1'b1;
                end
            end
        endcase
    end

`ifdef SNAKE_WRAP_EN
    assign w_wall = 1'b0;
    logic w_unused_edge;
    assign w_unused_edge = w_edge;
`else
    assign w_wall = w_edge;
`endif

    // Self hit: new head lands on a body segment; the tail is
    // exempt when it is about to vacate its cell.
    always_comb begin
        w_self = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((6'(i) < r_len)
                && ((6'(i) != r_len - 6'd1) || w_len_inc)
                && (r_seg_x[i] == w_nx)
                && (r_seg_y[i] == w_ny)) begin
                w_self = 1'b1;
            end
        end
    end

    // Game state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and step decision.
    always_comb begin
        w_state_nxt = r_state;
        w_move      = 1'b0;
        w_reinit    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.tick) begin
                    if (w_wall || w_self) begin
                        w_state_nxt = S_OVER;
                    end else begin
                        w_move = 1'b1;
                    end
                end
            end
            S_OVER: begin
                if (bus.start) begin
                    w_state_nxt = S_IDLE;
                    w_reinit    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Body history, length, pending growth and move pulse.
    always_ff @(posedge clk) begin
        if (reset || w_reinit) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                if (i < START_LEN) begin
                    r_seg_x[i] <= XW'(START_X - i);
                    r_seg_y[i] <= YW'(START_Y);
                end else begin
                    r_seg_x[i] <= '0;
                    r_seg_y[i] <= '0;
                end
            end
            r_len          <= 6'(START_LEN);
            r_grow_pending <= 1'b0;
            r_moved        <= 1'b0;
        end else begin
            r_moved <= w_move;
            if ((r_state == S_RUN) && bus.grow) begin
                r_grow_pending <= 1'b1;
            end
            if (w_move) begin
                for (int i = 1; i < MAX_LEN; i++) begin
                    r_seg_x[i] <= r_seg_x[i-1];
                    r_seg_y[i] <= r_seg_y[i-1];
                end
                r_seg_x[0]     <= w_nx;
                r_seg_y[0]     <= w_ny;
                r_grow_pending <= 1'b0;
                if (w_len_inc) begin
                    r_len <= r_len + 6'd1;
                end
            end
        end
    end

    // Cell query against the active segments only.
    always_comb begin
        w_occ = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((6'(i) < r_len)
                && (r_seg_x[i] == bus.qx)
                && (r_seg_y[i] == bus.qy)) begin
                w_occ = 1'b1;
            end
        end
    end

    assign bus.occupied  = w_occ;
    assign bus.head_x    = r_seg_x[0];
    assign bus.head_y    = r_seg_y[0];
    assign bus.len       = r_len;
    assign bus.moved     = r_moved;
    assign bus.game_over = (r_state == S_OVER);
    assign bus.running   = (r_state == S_RUN);

endmodule

// File: tb/tb_snake_body_tracker.sv
// Bench for snake_body_tracker: queue-based body model plus
// hand-computed scenario checks.
module tb_snake_body_tracker;

    localparam int GW = 16;
    localparam int GH = 16;
    localparam int ML = 8;
    localparam int SX = 4;
    localparam int SY = 8;
    localparam int SL = 3;

    localparam logic [3:0] L = 4'b0000;
    localparam logic [3:0] R = 4'b1101;
    localparam logic [3:0] U = 4'b0110;
    localparam logic [3:0] D = 4'b1011;

    logic clk = 1'b0;
    logic reset = 1'b1;
    bit   chk_en = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    snake_body_tracker_if #(.XW(4), .YW(4)) bus ();

    snake_body_tracker dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Model: body as a queue of encoded cells, head first.
    int body[$];
    int mst;
    bit mpend;
    bit mmoved;
    int nx, ny, e;
    bit wall, hit, g;

    function automatic int enc(int x, int y);
        return x * 256 + y;
    endfunction

    task automatic m_init();
        body.delete();
        for (int i = 0; i < SL; i++) body.push_back(enc(SX - i, SY));
        mst    = 0;
        mpend  = 1'b0;
        mmoved = 1'b0;
    endtask

    task automatic chk(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t",
                      name, act, exp, $time);
    endtask

    always @(posedge clk) begin
        mmoved = 1'b0;
        if (reset) begin
            m_init();
        end else if (mst == 0) begin
            if (bus.start) mst = 1;
        end else if (mst == 1) begin
            if (bus.grow) mpend = 1'b1;
            if (bus.tick) begin
                nx = body[0] / 256;
                ny = body[0] % 256;
                case (bus.dir[1:0])
                    2'b00: nx = nx - 1;
                    2'b01: nx = nx + 1;
                    2'b10: ny = ny - 1;
                    default: ny = ny + 1;
                endcase
                wall = (nx < 0) || (nx >= GW) || (ny < 0) || (ny >= GH);
`ifdef SNAKE_WRAP_EN
                wall = 1'b0;
                nx = (nx + GW) % GW;
                ny = (ny + GH) % GH;
`endif
                e = enc(nx, ny);
                g = mpend && (body.size() < ML);
                hit = 1'b0;
                for (int i = 1; i < body.size(); i++) begin
                    if (!(i == body.size() - 1 && !g) && body[i] == e)
                        hit = 1'b1;
                end
                if (wall || hit) begin
                    mst = 2;
                end else begin
                    body.push_front(e);
                    if (!g) void'(body.pop_back());
                    mpend  = 1'b0;
                    mmoved = 1'b1;
                end
            end
        end else begin
            if (bus.start) m_init();
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        int occ;
        if (chk_en) begin
            occ = 0;
            foreach (body[i])
                if (body[i] == enc(int'(bus.qx), int'(bus.qy))) occ = 1;
            chk("m_head_x", int'(bus.head_x), body[0] / 256);
            chk("m_head_y", int'(bus.head_y), body[0] % 256);
            chk("m_len", int'(bus.len), body.size());
            chk("m_moved", int'(bus.moved), int'(mmoved));
            chk("m_over", int'(bus.game_over), int'(mst == 2));
            chk("m_run", int'(bus.running), int'(mst == 1));
            chk("m_occ", int'(bus.occupied), occ);
        end
    end

    task automatic cyc(input logic [3:0] d, input bit t, input bit gr,
                       input bit s, input bit r);
        bus.dir   = d;
        bus.tick  = t;
        bus.grow  = gr;
        bus.start = s;
        reset     = r;
        @(posedge clk);
        #1;
        bus.tick  = 1'b0;
        bus.grow  = 1'b0;
        bus.start = 1'b0;
        reset     = 1'b0;
        bus.qx    = 4'($urandom_range(0, 15));
        bus.qy    = 4'($urandom_range(0, 15));
    endtask

    task automatic restart();
        cyc(R, 0, 0, 0, 1);
        cyc(R, 0, 0, 1, 0);
    endtask

    initial begin
        bus.dir   = 4'd0;
        bus.tick  = 1'b0;
        bus.grow  = 1'b0;
        bus.start = 1'b0;
        bus.qx    = 4'd0;
        bus.qy    = 4'd0;
        cyc(R, 0, 0, 0, 1);
        chk_en = 1'b1;
        chk("rst_head_x", int'(bus.head_x), 4);
        chk("rst_len", int'(bus.len), 3);
        chk("rst_run", int'(bus.running), 0);

        // Idle ignores a tick alongside start.
        cyc(R, 1, 1, 1, 0);
        chk("start_run", int'(bus.running), 1);
        chk("start_head", int'(bus.head_x), 4);
        for (int i = 0; i < 3; i++) begin
            cyc(R, 1, 0, 0, 0);
            chk("move_pulse", int'(bus.moved), 1);
        end
        chk("t1_head_x", int'(bus.head_x), 7);
        chk("t1_head_y", int'(bus.head_y), 8);
        chk("t1_len", int'(bus.len), 3);
        bus.qx = 4'd5; bus.qy = 4'd8; #1;
        chk("t1_occ_tail", int'(bus.occupied), 1);
        bus.qx = 4'd4; #1;
        chk("t1_occ_free", int'(bus.occupied), 0);

        // Growth and saturation.
        cyc(R, 1, 1, 0, 0);
        chk("grow_len4", int'(bus.len), 4);
        for (int i = 0; i < 6; i++) cyc(R, 1, 1, 0, 0);
        chk("grow_sat", int'(bus.len), 8);
        chk("grow_sat_x", int'(bus.head_x), 14);

        restart();
        cyc(R, 0, 1, 0, 0);
        cyc(R, 0, 1, 0, 0);
        cyc(R, 1, 0, 0, 0);
        chk("grow_once_a", int'(bus.len), 4);
        cyc(R, 1, 0, 0, 0);
        chk("grow_once_b", int'(bus.len), 4);

        // Right wall.
        restart();
        for (int i = 0; i < 11; i++) cyc(R, 1, 0, 0, 0);
        chk("edge_x", int'(bus.head_x), 15);
        cyc(R, 1, 0, 0, 0);
`ifdef SNAKE_WRAP_EN
        chk("wrap_x", int'(bus.head_x), 0);
        chk("wrap_run", int'(bus.running), 1);
`else
        chk("wall_over", int'(bus.game_over), 1);
        chk("wall_x", int'(bus.head_x), 15);
        cyc(R, 1, 1, 0, 0);
        chk("wall_frozen", int'(bus.head_x), 15);
        chk("wall_len", int'(bus.len), 3);
`endif

        // Self collision with a length-5 body.
        restart();
        cyc(R, 1, 1, 0, 0);
        cyc(R, 1, 1, 0, 0);
        cyc(R, 1, 0, 0, 0);
        chk("self_len5", int'(bus.len), 5);
        chk("self_x7", int'(bus.head_x), 7);
        cyc(U, 1, 0, 0, 0);
        cyc(L, 1, 0, 0, 0);
        cyc(D, 1, 0, 0, 0);
        chk("self_over", int'(bus.game_over), 1);
        chk("self_hx", int'(bus.head_x), 6);
        chk("self_hy", int'(bus.head_y), 7);

        // Reversal, then re-initialise.
        restart();
        cyc(L, 1, 0, 0, 0);
        chk("rev_over", int'(bus.game_over), 1);
        cyc(L, 0, 0, 1, 0);
        chk("reinit_over", int'(bus.game_over), 0);
        chk("reinit_run", int'(bus.running), 0);
        chk("reinit_x", int'(bus.head_x), 4);
        chk("reinit_y", int'(bus.head_y), 8);
        chk("reinit_len", int'(bus.len), 3);

        // Reset wins over a tick mid-run.
        restart();
        cyc(R, 1, 1, 0, 0);
        cyc(R, 1, 0, 0, 0);
        cyc(R, 1, 1, 0, 1);
        chk("mrst_x", int'(bus.head_x), 4);
        chk("mrst_len", int'(bus.len), 3);
        chk("mrst_run", int'(bus.running), 0);
        chk("mrst_moved", int'(bus.moved), 0);

        // Random play checked by the model.
        for (int i = 0; i < 4000; i++) begin
            cyc(4'($urandom),
                ($urandom % 2) == 0,
                ($urandom % 5) == 0,
                ($urandom % 8) == 0,
                ($urandom % 250) == 0);
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
